// File: rtl/stall_ctrl_pkg.sv
// Shared encodings for the pipeline stall controller: Tuse/Tnew codes, MDU op type
// and default MDU latencies.
package stall_ctrl_pkg;

  // Tuse of 3 marks an unused source; no Tnew can exceed it, so it never stalls.
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    MdMult = 1'b0,
    MdDiv  = 1'b1
  } md_type_e;

  typedef enum logic {
    StIdle,
    StBusy
  } md_state_e;

  // True when a D-stage source is written by an in-flight instruction that will not
  // have its result ready in time for forwarding.
  function automatic logic grf_hit(input logic [4:0] d_reg, input logic [1:0] d_tuse,
                                   input logic [4:0] w_a3, input logic w_we,
                                   input logic [1:0] w_tnew);
    return (d_reg != 5'd0) && w_we && (w_a3 == d_reg) && (w_tnew > d_tuse);
  endfunction

endpackage

// File: rtl/stall_ctrl_md_busy_counter.sv
// Multiply/divide busy-window countdown; a start in E loads the op latency and the
// count then drains to zero.
module stall_ctrl_md_busy_counter
  import stall_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic start_i,
  input  logic div_i,
  output logic busy_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_state_e        state;
  md_type_e         md_type;

  assign md_type = md_type_e'(div_i);
  assign state   = (cnt_q == '0) ? StIdle : StBusy;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      // A start always reloads, even mid-countdown.
      cnt_d = (md_type == MdDiv) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else begin
      unique case (state)
        StIdle:  cnt_d = '0;
        StBusy:  cnt_d = cnt_q - 1'b1;
        default: cnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (state == StBusy);

endmodule

// File: rtl/stall_ctrl.sv
// Hazard/sequencing controller for the five-stage pipeline: GRF Tuse/Tnew stalls and
// MDU busy stalls. Define STALL_PERF_EN to add the stall performance counters.
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_Tuse_rs,
  input  logic [1:0]  D_Tuse_rt,
  input  logic        D_is_md,
  input  logic [4:0]  E_A3,
  input  logic        E_Wegrf,
  input  logic [1:0]  E_Tnew,
  input  logic [4:0]  M_A3,
  input  logic        M_Wegrf,
  input  logic [1:0]  M_Tnew,
  input  logic        E_md_start,
  input  logic        E_md_div,
  output logic        stall,
  output logic        F_en,
  output logic        D_en,
  output logic        E_flush,
  output logic        md_busy
`ifdef STALL_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] md_stall_cnt
`endif
);

  logic busy;
  logic stall_grf;
  logic stall_md;
  logic stall_raw;

  stall_ctrl_md_busy_counter #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_md_busy_counter (
    .clk_i  (clk),
    .reset_i(reset),
    .start_i(E_md_start),
    .div_i  (E_md_div),
    .busy_o (busy)
  );

  always_comb begin
    stall_grf = grf_hit(D_rs, D_Tuse_rs, E_A3, E_Wegrf, E_Tnew) |
                grf_hit(D_rs, D_Tuse_rs, M_A3, M_Wegrf, M_Tnew) |
                grf_hit(D_rt, D_Tuse_rt, E_A3, E_Wegrf, E_Tnew) |
                grf_hit(D_rt, D_Tuse_rt, M_A3, M_Wegrf, M_Tnew);
    // Outputs are forced quiet while reset is held so stage registers free-run.
    stall_md  = D_is_md & (busy | E_md_start) & ~reset;
    stall_raw = (stall_grf & ~reset) | stall_md;
  end

  assign stall   = stall_raw;
  assign F_en    = ~stall_raw;
  assign D_en    = ~stall_raw;
  assign E_flush = stall_raw;
  assign md_busy = busy & ~reset;

`ifdef STALL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] md_stall_cnt_q, md_stall_cnt_d;

  always_comb begin
    stall_cnt_d    = stall_cnt_q + {31'd0, stall_raw};
    md_stall_cnt_d = md_stall_cnt_q + {31'd0, stall_md};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q    <= '0;
      md_stall_cnt_q <= '0;
    end else begin
      stall_cnt_q    <= stall_cnt_d;
      md_stall_cnt_q <= md_stall_cnt_d;
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign md_stall_cnt = md_stall_cnt_q;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl: per-cycle expectations go through a scoreboard queue
// and are checked at the falling edge.
module tb_stall_ctrl;
  import stall_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] D_rs, D_rt, E_A3, M_A3;
  logic [1:0] D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
  logic       D_is_md, E_Wegrf, M_Wegrf, E_md_start, E_md_div;
  logic       stall, F_en, D_en, E_flush, md_busy;
`ifdef STALL_PERF_EN
  logic [31:0] stall_cnt, md_stall_cnt;
`endif

  typedef struct {
    string tag;
    logic  stall;
    logic  busy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  stall_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .D_rs        (D_rs),
    .D_rt        (D_rt),
    .D_Tuse_rs   (D_Tuse_rs),
    .D_Tuse_rt   (D_Tuse_rt),
    .D_is_md     (D_is_md),
    .E_A3        (E_A3),
    .E_Wegrf     (E_Wegrf),
    .E_Tnew      (E_Tnew),
    .M_A3        (M_A3),
    .M_Wegrf     (M_Wegrf),
    .M_Tnew      (M_Tnew),
    .E_md_start  (E_md_start),
    .E_md_div    (E_md_div),
    .stall       (stall),
    .F_en        (F_en),
    .D_en        (D_en),
    .E_flush     (E_flush),
    .md_busy     (md_busy)
`ifdef STALL_PERF_EN
    ,
    .stall_cnt   (stall_cnt),
    .md_stall_cnt(md_stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    D_rs = 5'd0; D_rt = 5'd0; D_Tuse_rs = TUSE_NONE; D_Tuse_rt = TUSE_NONE;
    D_is_md = 1'b0; E_A3 = 5'd0; E_Wegrf = 1'b0; E_Tnew = 2'd0;
    M_A3 = 5'd0; M_Wegrf = 1'b0; M_Tnew = 2'd0; E_md_start = 1'b0; E_md_div = 1'b0;
  endtask

  // Queue the expectation for the current cycle, check it mid-cycle, move to the next.
  task automatic step(input string tag, input logic exp_stall, input logic exp_busy);
    exp_t e;
    e.tag = tag; e.stall = exp_stall; e.busy = exp_busy;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk({e.tag, ".stall"},   {31'd0, stall},   {31'd0, e.stall});
    chk({e.tag, ".F_en"},    {31'd0, F_en},    {31'd0, ~e.stall});
    chk({e.tag, ".D_en"},    {31'd0, D_en},    {31'd0, ~e.stall});
    chk({e.tag, ".E_flush"}, {31'd0, E_flush}, {31'd0, e.stall});
    chk({e.tag, ".md_busy"}, {31'd0, md_busy}, {31'd0, e.busy});
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    // Hazard and MDU request present while reset is held: must not stall.
    E_A3 = 5'd8; E_Wegrf = 1'b1; E_Tnew = 2'd2; D_rs = 5'd8; D_Tuse_rs = 2'd0;
    D_is_md = 1'b1; E_md_start = 1'b1;
    step("rst_hold", 1'b0, 1'b0);
    reset = 1'b0;
    clear_inputs();
    step("idle", 1'b0, 1'b0);

    E_A3 = 5'd8; E_Wegrf = 1'b1; E_Tnew = 2'd2; D_rs = 5'd8; D_Tuse_rs = 2'd0;
    step("e_rs_hit", 1'b1, 1'b0);
    D_rs = 5'd0;
    step("rs_zero", 1'b0, 1'b0);
    clear_inputs();

    M_A3 = 5'd9; M_Wegrf = 1'b1; M_Tnew = 2'd1; D_rt = 5'd9; D_Tuse_rt = 2'd1;
    step("m_rt_eq", 1'b0, 1'b0);
    D_Tuse_rt = 2'd0;
    step("m_rt_hit", 1'b1, 1'b0);
    clear_inputs();

    E_A3 = 5'd8; E_Wegrf = 1'b1; E_Tnew = 2'd1; D_rs = 5'd8; D_Tuse_rs = 2'd1;
    step("e_rs_eq", 1'b0, 1'b0);
    D_Tuse_rs = 2'd0;
    step("e_rs_lt", 1'b1, 1'b0);
    E_Tnew = 2'd2; D_Tuse_rs = TUSE_NONE;
    step("rs_unused", 1'b0, 1'b0);
    D_Tuse_rs = 2'd0; E_Wegrf = 1'b0;
    step("no_wegrf", 1'b0, 1'b0);
    clear_inputs();

    // Mult issues from E at cycle 0; dependent MDU op held in D.
    E_md_start = 1'b1; E_md_div = 1'b0; D_is_md = 1'b1;
    step("mult_c0", 1'b1, 1'b0);
    E_md_start = 1'b0;
    for (int i = 1; i <= 5; i++) step($sformatf("mult_c%0d", i), 1'b1, 1'b1);
    step("mult_c6", 1'b0, 1'b0);
    step("mult_c7", 1'b0, 1'b0);
`ifdef STALL_PERF_EN
    chk("stall_cnt", stall_cnt, 32'd9);
    chk("md_stall_cnt", md_stall_cnt, 32'd6);
`endif

    // Div then reset at cycle 4: no residual busy afterwards.
    E_md_start = 1'b1; E_md_div = 1'b1;
    step("div_c0", 1'b1, 1'b0);
    E_md_start = 1'b0;
    for (int i = 1; i <= 3; i++) step($sformatf("div_c%0d", i), 1'b1, 1'b1);
    reset = 1'b1;
    step("div_rst_c4", 1'b0, 1'b0);
    reset = 1'b0;
    step("div_c5", 1'b0, 1'b0);
    step("div_c6", 1'b0, 1'b0);
`ifdef STALL_PERF_EN
    chk("stall_cnt_rst", stall_cnt, 32'd0);
    chk("md_stall_cnt_rst", md_stall_cnt, 32'd0);
`endif
    clear_inputs();

    // Mult start immediately followed by a div start: the div latency replaces it.
    E_md_start = 1'b1; E_md_div = 1'b0;
    step("reload_c0", 1'b0, 1'b0);
    E_md_div = 1'b1;
    step("reload_c1", 1'b0, 1'b1);
    E_md_start = 1'b0; E_md_div = 1'b0;
    for (int i = 2; i <= 11; i++) step($sformatf("reload_c%0d", i), 1'b0, 1'b1);
    step("reload_c12", 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
